// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller:
// bus widths, stage indices, the default exception vector and the stall encoder.
package pipeline_ctrl_pkg;

    localparam int ADDR_WIDTH      = 32;
    localparam int STALL_BUS_WIDTH = 6;

    typedef logic [ADDR_WIDTH-1:0]      addr_t;
    typedef logic [STALL_BUS_WIDTH-1:0] stall_t;

    localparam int STAGE_PC  = 0;
    localparam int STAGE_IF  = 1;
    localparam int STAGE_ID  = 2;
    localparam int STAGE_EX  = 3;
    localparam int STAGE_MEM = 4;
    localparam int STAGE_WB  = 5;

    localparam addr_t EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    // Freezes PC..EXMEM while MEMWB keeps loading bubbles.
    localparam stall_t STALL_HOLD = 6'b01_1111;

    // A request from stage s stalls every stage up to and including s; WB never stalls.
    function automatic stall_t stall_from_requests(input logic [STAGE_MEM:STAGE_IF] req);
        stall_t s;
        s = '0;
        for (int k = STAGE_IF; k <= STAGE_MEM; k++) begin
            if (req[k]) begin
                for (int j = STAGE_PC; j <= k; j++) begin
                    s[j] = 1'b1;
                end
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Signal bundle between the pipeline stages and the stall/flush controller.
// master = controller side, slave = pipeline side.
interface pipeline_ctrl_if
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32
);
    logic                 stall_req_if;
    logic                 stall_req_id;
    logic                 stall_req_ex;
    logic                 stall_req_mem;
    logic                 if_bus_busy;
    logic                 exception_valid;
    logic                 exception_eret;
    addr_t                cp0_epc;
    logic                 counter_clear;
    stall_t               stall;
    logic                 flush;
    addr_t                flush_pc;
    logic [CNT_WIDTH-1:0] stall_cycles;
    logic [CNT_WIDTH-1:0] flush_count;

    modport master (
        input  stall_req_if, stall_req_id, stall_req_ex, stall_req_mem,
        input  if_bus_busy, exception_valid, exception_eret, cp0_epc, counter_clear,
        output stall, flush, flush_pc, stall_cycles, flush_count
    );

    modport slave (
        output stall_req_if, stall_req_id, stall_req_ex, stall_req_mem,
        output if_bus_busy, exception_valid, exception_eret, cp0_epc, counter_clear,
        input  stall, flush, flush_pc, stall_cycles, flush_count
    );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module pipeline_ctrl_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline. Exceptions accepted at MEM
// flush the pipe and redirect the PC; the flush is deferred while an I-bus fetch is in flight.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter addr_t EXC_VECTOR = EXC_VECTOR_DEFAULT,
    parameter int    CNT_WIDTH  = 32
) (
    input  logic     clk,
    input  logic     rst,
    pipeline_ctrl_if.master bus
);

    localparam logic [0:0] ST_RUN        = 1'b0;
    localparam logic [0:0] ST_FLUSH_WAIT = 1'b1;

    logic [0:0] state;
    logic [0:0] state_next;
    addr_t      pending_pc;
    logic       latch_pending;
    addr_t      exc_target;
    stall_t     req_stall;

    assign req_stall  = stall_from_requests({bus.stall_req_mem, bus.stall_req_ex,
                                             bus.stall_req_id, bus.stall_req_if});
    assign exc_target = bus.exception_eret ? bus.cp0_epc : EXC_VECTOR;

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_next    = state;
        latch_pending = 1'b0;
        bus.stall     = '0;
        bus.flush     = 1'b0;
        bus.flush_pc  = '0;
        case (state)
            ST_RUN: begin
                if (!bus.exception_valid) begin
                    bus.stall = req_stall;
                end else if (!bus.if_bus_busy) begin
                    bus.flush    = 1'b1;
                    bus.flush_pc = exc_target;
                end else begin
                    bus.stall     = STALL_HOLD;
                    latch_pending = 1'b1;
                    state_next    = ST_FLUSH_WAIT;
                end
            end
            ST_FLUSH_WAIT: begin
                // The in-flight fetch cannot be aborted; everything else waits for it.
                if (bus.if_bus_busy) begin
                    bus.stall = STALL_HOLD;
                end else begin
                    bus.flush    = 1'b1;
                    bus.flush_pc = pending_pc;
                    state_next   = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_RUN;
            pending_pc <= '0;
        end else begin
            state <= state_next;
            if (latch_pending) begin
                pending_pc <= exc_target;
            end
        end
    end

    pipeline_ctrl_sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (bus.counter_clear),
        .inc   (bus.stall[STAGE_PC]),
        .count (bus.stall_cycles)
    );

    pipeline_ctrl_sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (bus.counter_clear),
        .inc   (bus.flush),
        .count (bus.flush_count)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a 32-bit-counter instance for the main scenarios
// and a 4-bit-counter instance for saturation.
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pipeline_ctrl_if #(.CNT_WIDTH(32)) bus32 ();
    pipeline_ctrl_if #(.CNT_WIDTH(4))  bus4 ();

    pipeline_ctrl #(.CNT_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus32)
    );

    pipeline_ctrl #(.CNT_WIDTH(4)) dut_small (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus32.stall_req_if    = 1'b0;
        bus32.stall_req_id    = 1'b0;
        bus32.stall_req_ex    = 1'b0;
        bus32.stall_req_mem   = 1'b0;
        bus32.if_bus_busy     = 1'b0;
        bus32.exception_valid = 1'b0;
        bus32.exception_eret  = 1'b0;
        bus32.cp0_epc         = 32'h0;
        bus32.counter_clear   = 1'b0;
        bus4.stall_req_if     = 1'b0;
        bus4.stall_req_id     = 1'b0;
        bus4.stall_req_ex     = 1'b0;
        bus4.stall_req_mem    = 1'b0;
        bus4.if_bus_busy      = 1'b0;
        bus4.exception_valid  = 1'b0;
        bus4.exception_eret   = 1'b0;
        bus4.cp0_epc          = 32'h0;
        bus4.counter_clear    = 1'b0;
    endtask

    // Advance one clock edge; inputs are then driven 1 ns after it and outputs sampled 2 ns after.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        #1;
        check("rst_stall", 32'(bus32.stall), 32'h0);
        check("rst_flush", 32'(bus32.flush), 32'h0);
        check("rst_flush_pc", bus32.flush_pc, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("rst_stall_cycles", bus32.stall_cycles, 32'h0);
        check("rst_flush_count", bus32.flush_count, 32'h0);

        // 1. stall priority
        bus32.stall_req_ex = 1'b1;
        #1 check("ex_stall", 32'(bus32.stall), 32'h0F);
        check("ex_flush", 32'(bus32.flush), 32'h0);
        tick();
        bus32.stall_req_if = 1'b1;
        #1 check("ex_if_stall", 32'(bus32.stall), 32'h0F);
        tick();
        bus32.stall_req_mem = 1'b1;
        #1 check("mem_stall", 32'(bus32.stall), 32'h1F);
        tick();
        idle();
        #1 check("release_stall", 32'(bus32.stall), 32'h0);
        check("stall_cycles_3", bus32.stall_cycles, 32'd3);
        bus32.counter_clear = 1'b1;
        tick();
        bus32.counter_clear = 1'b0;
        #1 check("clear_stall_cycles", bus32.stall_cycles, 32'd0);

        // 2. immediate exception overrides stall requests
        bus32.stall_req_mem   = 1'b1;
        bus32.exception_valid = 1'b1;
        #1 check("exc_flush", 32'(bus32.flush), 32'h1);
        check("exc_flush_pc", bus32.flush_pc, 32'hBFC0_0380);
        check("exc_stall", 32'(bus32.stall), 32'h0);
        tick();
        idle();
        #1 check("exc_flush_drop", 32'(bus32.flush), 32'h0);
        check("exc_flush_count", bus32.flush_count, 32'd1);
        check("exc_no_stall_cnt", bus32.stall_cycles, 32'd0);

        // 3. ERET deferred behind a busy instruction fetch
        bus32.exception_valid = 1'b1;
        bus32.exception_eret  = 1'b1;
        bus32.cp0_epc         = 32'h8000_1234;
        bus32.if_bus_busy     = 1'b1;
        #1 check("defer_c1_stall", 32'(bus32.stall), 32'h1F);
        check("defer_c1_flush", 32'(bus32.flush), 32'h0);
        check("defer_c1_flush_pc", bus32.flush_pc, 32'h0);
        tick();
        bus32.cp0_epc = 32'h0;
        #1 check("defer_c2_stall", 32'(bus32.stall), 32'h1F);
        check("defer_c2_flush", 32'(bus32.flush), 32'h0);
        tick();
        #1 check("defer_c3_stall", 32'(bus32.stall), 32'h1F);
        tick();
        idle();
        #1 check("defer_flush", 32'(bus32.flush), 32'h1);
        check("defer_flush_pc", bus32.flush_pc, 32'h8000_1234);
        check("defer_flush_stall", 32'(bus32.stall), 32'h0);
        tick();
        #1 check("defer_flush_drop", 32'(bus32.flush), 32'h0);
        check("defer_stall_cycles", bus32.stall_cycles, 32'd3);
        check("defer_flush_count", bus32.flush_count, 32'd2);

        // 4. async reset while waiting discards the pending flush
        bus32.exception_valid = 1'b1;
        bus32.if_bus_busy     = 1'b1;
        tick();
        bus32.exception_valid = 1'b0;
        #1 check("wait_stall", 32'(bus32.stall), 32'h1F);
        #1 rst = 1'b1;
        #1 check("arst_stall", 32'(bus32.stall), 32'h0);
        check("arst_flush", 32'(bus32.flush), 32'h0);
        check("arst_stall_cycles", bus32.stall_cycles, 32'd0);
        check("arst_flush_count", bus32.flush_count, 32'd0);
        rst = 1'b0;
        bus32.if_bus_busy = 1'b0;
        #1 check("arst_no_flush", 32'(bus32.flush), 32'h0);
        tick();
        #1 check("arst_no_flush_next", 32'(bus32.flush), 32'h0);
        check("arst_flush_count_after", bus32.flush_count, 32'd0);

        // 5. 4-bit saturation and clear-over-increment
        bus4.stall_req_id = 1'b1;
        #1 check("id_stall", 32'(bus4.stall), 32'h07);
        for (int i = 0; i < 14; i++) tick();
        check("sat_14", 32'(bus4.stall_cycles), 32'hE);
        for (int i = 0; i < 6; i++) tick();
        check("sat_hold", 32'(bus4.stall_cycles), 32'hF);
        bus4.counter_clear = 1'b1;
        tick();
        bus4.counter_clear = 1'b0;
        check("sat_clear", 32'(bus4.stall_cycles), 32'h0);
        tick();
        check("sat_restart", 32'(bus4.stall_cycles), 32'h1);
        bus4.stall_req_id = 1'b0;

        // 6. back-to-back immediate exceptions
        bus32.exception_valid = 1'b1;
        #1 check("b2b1_flush", 32'(bus32.flush), 32'h1);
        check("b2b1_flush_pc", bus32.flush_pc, 32'hBFC0_0380);
        tick();
        bus32.exception_eret = 1'b1;
        bus32.cp0_epc        = 32'h1234_5678;
        #1 check("b2b2_flush", 32'(bus32.flush), 32'h1);
        check("b2b2_flush_pc", bus32.flush_pc, 32'h1234_5678);
        tick();
        idle();
        #1 check("b2b_flush_drop", 32'(bus32.flush), 32'h0);
        check("b2b_flush_pc_zero", bus32.flush_pc, 32'h0);
        check("b2b_flush_count", bus32.flush_count, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
